// File: rtl/alu_issue_ctrl.sv
// Issue controller for a single-cycle/two-cycle ALU: accepts one request at a time,
// drives the ALU from registered operands and holds the captured result until consumed.
module alu_issue_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_data1_i,
    input  logic [31:0] req_data2_i,
    output logic [31:0] alu_data1_o,
    output logic [31:0] alu_data2_o,
    output logic [2:0]  alu_ctrl_o,
    input  logic [31:0] alu_result_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_result_o,
    output logic        rsp_err_o,
    output logic [15:0] done_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [2:0] CTRL_IDLE = 3'b000;
    localparam logic [2:0] CTRL_ADD  = 3'b001;
    localparam logic [2:0] CTRL_SUB  = 3'b010;
    localparam logic [2:0] CTRL_AND  = 3'b011;
    localparam logic [2:0] CTRL_OR   = 3'b100;
    localparam logic [2:0] CTRL_MUL  = 3'b101;

    state_t      state_q, state_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] result_q, result_d;
    logic        err_q, err_d;
    logic [15:0] done_cnt_q, done_cnt_d;

    logic [2:0]  dec_ctrl;
    logic        dec_illegal;

    always_comb begin
        dec_ctrl    = CTRL_IDLE;
        dec_illegal = 1'b0;
        case (req_op_i)
            3'b000:  dec_ctrl = CTRL_ADD;
            3'b001:  dec_ctrl = CTRL_SUB;
            3'b010:  dec_ctrl = CTRL_AND;
            3'b011:  dec_ctrl = CTRL_OR;
            3'b100:  dec_ctrl = CTRL_MUL;
            default: dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        ctrl_d     = ctrl_q;
        result_d   = result_q;
        err_d      = err_q;
        done_cnt_d = done_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    op1_d  = req_data1_i;
                    op2_d  = req_data2_i;
                    ctrl_d = dec_ctrl;
                    if (dec_illegal) begin
                        // Illegal ops skip the ALU entirely and answer with a zero result.
                        result_d = 32'd0;
                        err_d    = 1'b1;
                        state_d  = RESP;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (ctrl_q == CTRL_MUL) begin
                    state_d = WAIT;
                end else begin
                    result_d = alu_result_i;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end
            end
            WAIT: begin
                result_d = alu_result_i;
                err_d    = 1'b0;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    done_cnt_d = done_cnt_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            op1_q      <= 32'd0;
            op2_q      <= 32'd0;
            ctrl_q     <= CTRL_IDLE;
            result_q   <= 32'd0;
            err_q      <= 1'b0;
            done_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            ctrl_q     <= ctrl_d;
            result_q   <= result_d;
            err_q      <= err_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign rsp_valid_o  = (state_q == RESP);
    assign alu_ctrl_o   = (state_q == EXEC || state_q == WAIT) ? ctrl_q : CTRL_IDLE;
    assign alu_data1_o  = op1_q;
    assign alu_data2_o  = op2_q;
    assign rsp_result_o = result_q;
    assign rsp_err_o    = err_q;
    assign done_cnt_o   = done_cnt_q;

endmodule
